// File: rtl/clock_reset_sequencer.sv
// Power-up sequencer: releases peripheral reset, then CPU reset, once PLL lock
// and the debounced reset button have been stable long enough.
module clock_reset_sequencer #(
  parameter int LOCK_CYCLES      = 1024,
  parameter int CPU_DELAY_CYCLES = 256,
  parameter int DEBOUNCE_CYCLES  = 65536
) (
  input  logic clock,
  input  logic reset_n,
  input  logic locked,
  input  logic button_n,
  input  logic clear_lost,
  output logic periph_reset_n,
  output logic cpu_reset_n,
  output logic ready,
  output logic lock_lost
);

  localparam int MAX_CYC = (LOCK_CYCLES > CPU_DELAY_CYCLES) ? LOCK_CYCLES : CPU_DELAY_CYCLES;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int DW      = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_CYCLES - 1);
  localparam logic [CW-1:0] CPU_LAST  = CW'(CPU_DELAY_CYCLES - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {WAIT_LOCK, STABLE, PERIPH, RUN} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [DW-1:0] deb_cnt;
  logic          lock_meta, lock_s, btn_meta, btn_s, btn_d;
  logic          go, lost_set;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
      btn_meta  <= 1'b0;
      btn_s     <= 1'b0;
    end else begin
      lock_meta <= locked;
      lock_s    <= lock_meta;
      btn_meta  <= button_n;
      btn_s     <= btn_meta;
    end
  end

  // The counter must see DEBOUNCE_CYCLES completed cycles of difference before the
  // level flips, so the zeroed synchronizer after reset never pulses btn_d low.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      btn_d   <= 1'b1;
      deb_cnt <= '0;
    end else if (btn_s == btn_d) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_LAST) begin
      btn_d   <= btn_s;
      deb_cnt <= '0;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  assign go = lock_s & btn_d;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= WAIT_LOCK;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = '0;
    lost_set   = 1'b0;
    unique case (state)
      WAIT_LOCK: if (go) state_next = STABLE;
      STABLE: begin
        if (!go)                    state_next = WAIT_LOCK;
        else if (cnt == LOCK_LAST)  state_next = PERIPH;
        else                        cnt_next   = cnt + 1'b1;
      end
      PERIPH: begin
        if (!go)                    state_next = WAIT_LOCK;
        else if (cnt == CPU_LAST)   state_next = RUN;
        else                        cnt_next   = cnt + 1'b1;
      end
      RUN: begin
        if (!go) state_next = WAIT_LOCK;
        lost_set = !lock_s;
      end
      default: state_next = WAIT_LOCK;
    endcase
  end

  // Outputs are registered decodes of the state register, one edge behind it.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      periph_reset_n <= 1'b0;
      cpu_reset_n    <= 1'b0;
      ready          <= 1'b0;
      lock_lost      <= 1'b0;
    end else begin
      periph_reset_n <= (state == PERIPH) || (state == RUN);
      cpu_reset_n    <= (state == RUN);
      ready          <= (state == RUN);
      if (lost_set)        lock_lost <= 1'b1;
      else if (clear_lost) lock_lost <= 1'b0;
    end
  end

endmodule

// File: tb/tb_clock_reset_sequencer.sv
// Scoreboard bench for clock_reset_sequencer with LOCK=4, CPU_DELAY=3, DEBOUNCE=2.
// Expected {periph_reset_n, cpu_reset_n, ready, lock_lost} is queued per clock edge.
module tb_clock_reset_sequencer;

  logic clock = 1'b0;
  logic reset_n, locked, button_n, clear_lost;
  logic periph_reset_n, cpu_reset_n, ready, lock_lost;

  clock_reset_sequencer #(
    .LOCK_CYCLES(4),
    .CPU_DELAY_CYCLES(3),
    .DEBOUNCE_CYCLES(2)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .locked(locked),
    .button_n(button_n),
    .clear_lost(clear_lost),
    .periph_reset_n(periph_reset_n),
    .cpu_reset_n(cpu_reset_n),
    .ready(ready),
    .lock_lost(lock_lost)
  );

  always #5 clock = ~clock;

  int edge_n = 0;
  always @(posedge clock) edge_n++;

  typedef struct {
    int         e;
    logic [3:0] v;
  } exp_t;

  exp_t       sbq[$];
  int         checks   = 0;
  int         failures = 0;
  logic [3:0] act;

  task automatic push_exp(input int a, input int b, input logic [3:0] v);
    for (int i = a; i <= b; i++) sbq.push_back('{e: i, v: v});
  endtask

  task automatic wait_edge(input int e);
    while (edge_n < e) @(negedge clock);
  endtask

  // Monitor: compares outputs after every edge that has a queued expectation.
  always @(negedge clock) begin
    act = {periph_reset_n, cpu_reset_n, ready, lock_lost};
    while (sbq.size() > 0 && sbq[0].e < edge_n) begin
      checks++;
      failures++;
      $display("FAIL missed_edge%0d actual=none required=%b", sbq[0].e, sbq[0].v);
      void'(sbq.pop_front());
    end
    if (sbq.size() > 0 && sbq[0].e == edge_n) begin
      checks++;
      if (act !== sbq[0].v) begin
        failures++;
        $display("FAIL edge%0d {periph,cpu,ready,lost} actual=%b required=%b",
                 edge_n, act, sbq[0].v);
      end
      void'(sbq.pop_front());
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    reset_n    = 1'b0;
    locked     = 1'b1;
    button_n   = 1'b1;
    clear_lost = 1'b0;

    // Power-up: first sampling of locked at edge 3, periph at 10, cpu/ready at 13.
    push_exp(1, 9, 4'b0000);
    push_exp(10, 12, 4'b1000);
    push_exp(13, 15, 4'b1110);
    wait_edge(2);  reset_n = 1'b1;

    // Lock loss in RUN, sticky lock_lost through relock, then cleared.
    wait_edge(15);
    push_exp(16, 17, 4'b1110);
    push_exp(18, 18, 4'b1111);
    push_exp(19, 27, 4'b0001);
    push_exp(28, 30, 4'b1001);
    push_exp(31, 33, 4'b1111);
    push_exp(34, 35, 4'b1110);
    locked = 1'b0;
    wait_edge(20); locked = 1'b1;
    wait_edge(33); clear_lost = 1'b1;
    wait_edge(34); clear_lost = 1'b0;

    // Set/clear collision, then a STABLE lock glitch where abort beats count-complete.
    wait_edge(35);
    push_exp(36, 37, 4'b1110);
    push_exp(38, 38, 4'b1111);
    push_exp(39, 40, 4'b0001);
    push_exp(41, 53, 4'b0000);
    push_exp(54, 56, 4'b1000);
    push_exp(57, 59, 4'b1110);
    locked = 1'b0;
    wait_edge(37); clear_lost = 1'b1;
    wait_edge(38); clear_lost = 1'b0;
    wait_edge(39); locked = 1'b1;
    wait_edge(40); clear_lost = 1'b1;
    wait_edge(41); clear_lost = 1'b0;
    wait_edge(43); locked = 1'b0;
    wait_edge(46); locked = 1'b1;

    // Button: one-cycle glitch ignored; five-cycle press restarts without lock_lost.
    wait_edge(59);
    push_exp(60, 70, 4'b1110);
    push_exp(71, 79, 4'b0000);
    push_exp(80, 82, 4'b1000);
    push_exp(83, 85, 4'b1110);
    button_n = 1'b0;
    wait_edge(60); button_n = 1'b1;
    wait_edge(64); button_n = 1'b0;
    wait_edge(69); button_n = 1'b1;

    // Reset in RUN, then reset again while in PERIPH.
    wait_edge(85);
    push_exp(86, 93, 4'b0000);
    push_exp(94, 94, 4'b1000);
    push_exp(95, 102, 4'b0000);
    push_exp(103, 105, 4'b1000);
    push_exp(106, 108, 4'b1110);
    reset_n = 1'b0;
    wait_edge(86); reset_n = 1'b1;
    wait_edge(94); reset_n = 1'b0;
    wait_edge(95); reset_n = 1'b1;

    wait_edge(110);
    if (sbq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain actual=%0d_pending required=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clock_reset_sequencer.md
CLOCK_RESET_SEQUENCER -- requirements
Module: clock_reset_sequencer

Interface
REQ-001 Parameter LOCK_CYCLES, default 1024: consecutive cycles of synchronized lock required before peripheral reset release; legal range is 1 or greater.
REQ-002 Parameter CPU_DELAY_CYCLES, default 256: cycles between peripheral reset release and CPU reset release; legal range is 1 or greater.
REQ-003 Parameter DEBOUNCE_CYCLES, default 65536: consecutive stable cycles required to accept a reset-button level change; legal range is 1 or greater.
REQ-004 clock  input  1  system clock (PLL output, nominal 18.432 MHz); all logic rising-edge on this clock only.
REQ-005 reset_n  input  1  reset, synchronous, active-low.
REQ-006 locked  input  1  PLL lock indication, asynchronous to clock.
REQ-007 button_n  input  1  external reset push-button, active-low, asynchronous, bouncing.
REQ-008 clear_lost  input  1  single-cycle pulse that clears lock_lost.
REQ-009 periph_reset_n  output  1  peripheral/UART reset, active-low.
REQ-010 cpu_reset_n  output  1  Z180 core reset, active-low.
REQ-011 ready  output  1  high only in RUN.
REQ-012 lock_lost  output  1  sticky flag: lock dropped while in RUN.

Function
REQ-013 locked and button_n shall each pass through a 2-flop synchronizer; lock_s and btn_s denote the second-stage outputs.
REQ-014 Debounce: the debounced button level btn_d shall change only after btn_s differs from btn_d for DEBOUNCE_CYCLES consecutive cycles; any cycle with btn_s equal to btn_d clears the debounce counter.
REQ-015 The state machine shall have four states: WAIT_LOCK, STABLE, PERIPH and RUN.
REQ-016 In WAIT_LOCK, the block shall go to STABLE on the next edge when lock_s=1 and btn_d=1, with the counter cleared.
REQ-017 In STABLE, the counter shall increment each cycle and the block shall go to PERIPH on the edge where count==LOCK_CYCLES-1, with the counter cleared.
REQ-018 In PERIPH, the counter shall increment and the block shall go to RUN on the edge where count==CPU_DELAY_CYCLES-1.
REQ-019 In STABLE, PERIPH or RUN, lock_s=0 or btn_d=0 shall force WAIT_LOCK on the next edge with the counter cleared; this abort has priority over the count-complete transitions.
REQ-020 Outputs shall be decoded from the registered state only, with no combinational path from any input.
REQ-021 Output decode by state: WAIT_LOCK and STABLE give periph_reset_n=0, cpu_reset_n=0; PERIPH gives periph_reset_n=1, cpu_reset_n=0; RUN gives both 1.
REQ-022 ready shall be 1 only in RUN.
REQ-023 cpu_reset_n shall never be 1 while periph_reset_n is 0.
REQ-024 lock_lost shall be set on the edge leaving RUN due to lock_s=0.
REQ-025 lock_lost shall be cleared by clear_lost=1.
REQ-026 When set and clear_lost coincide, set shall win.
REQ-027 lock_lost shall not be set by a button-initiated exit or by a lock drop in STABLE or PERIPH.
REQ-028 The counter shall be sized to hold max(LOCK_CYCLES, CPU_DELAY_CYCLES)-1 and shall never wrap: it clears on every state change.
REQ-029 Timing: with locked rising and then held high, and btn_d=1, periph_reset_n shall rise exactly 3+LOCK_CYCLES edges after the first edge sampling locked=1; cpu_reset_n shall rise CPU_DELAY_CYCLES edges later.

Reset
REQ-030 On an edge with reset_n=0: state shall be WAIT_LOCK, all counters 0, synchronizer flops 0, btn_d=1, periph_reset_n=0, cpu_reset_n=0, ready=0, lock_lost=0.
REQ-031 Assertion of reset_n mid-sequence, in any state, shall take effect at the next edge, overriding all other transitions.

Verification (LOCK_CYCLES=4, CPU_DELAY_CYCLES=3, DEBOUNCE_CYCLES=2)
REQ-032 Power-up: reset_n low for 2 cycles then high, locked=1 from edge 0 -> periph_reset_n rises at edge 7 after the first sampling of locked, cpu_reset_n and ready rise at edge 10.
REQ-033 Lock glitch in STABLE: locked low for 3 cycles after 2 STABLE cycles -> outputs stay 0, sequence restarts from a zero count, lock_lost stays 0.
REQ-034 Lock loss in RUN: locked low -> 3 edges later both resets are 0, ready=0, lock_lost=1; lock_lost stays 1 after relock until clear_lost pulses.
REQ-035 Button: a 1-cycle low glitch on button_n -> no effect; button_n low for 5 cycles -> both resets asserted, lock_lost=0, full sequence replays after release.
REQ-036 Simultaneous events: clear_lost pulsed on the edge lock_lost is set -> lock_lost=1; reset_n driven low in PERIPH -> next edge both resets 0, state WAIT_LOCK.
